// File: rtl/channel_fallback_ctrl.sv
// channel_fallback_ctrl
// Main control FSM of the MPEG2-TS QoS controller. Picks one of four TS
// input channels as the active output, using per-channel presence, per-channel
// saturating error counts and a four-slot priority list. Supports a manual
// override and revertive automatic fallback with a holdoff between switches.
module channel_fallback_ctrl #(
  parameter int unsigned ERR_THRESH     = 8,
  parameter int unsigned HOLDOFF_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fallback_enable,
  input  logic        manual_enable,
  input  logic [1:0]  manual_channel,
  input  logic [7:0]  channel_priority,
  input  logic [19:0] reset_timer,
  input  logic [3:0]  signal_present,
  input  logic [3:0]  error_pulse,
  output logic [1:0]  active_channel,
  output logic [7:0]  error_count_ch0,
  output logic [7:0]  error_count_ch1,
  output logic [7:0]  error_count_ch2,
  output logic [7:0]  error_count_ch3,
  output logic        switch_pulse,
  output logic        no_signal
);

  typedef enum logic [2:0] {
    S_INIT,
    S_MANUAL,
    S_FIXED,
    S_ACTIVE,
    S_HOLDOFF
  } state_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES);
  localparam logic [7:0]  CNT_MAX   = 8'hFF;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ch_nxt;
  logic [15:0] holdoff_cnt;
  logic [15:0] hold_nxt;
  logic [19:0] period_cnt;
  logic        period_hit;
  logic        period_restart;
  logic [7:0]  err_cnt [4];
  logic [3:0]  healthy;
  logic        best_valid;
  logic [1:0]  best_ch;
  logic [2:0]  best_slot;
  logic [2:0]  cur_slot;
  logic [1:0]  slot_ch;
  logic        want_switch;

  // Status fields returned to the register block.
  assign error_count_ch0 = err_cnt[0];
  assign error_count_ch1 = err_cnt[1];
  assign error_count_ch2 = err_cnt[2];
  assign error_count_ch3 = err_cnt[3];

  // A period ends on the cycle the counter sits at reset_timer-1; a counter
  // already past a newly shortened period just restarts without clearing.
  always_comb begin
    period_hit     = (reset_timer != 20'd0) && (period_cnt == reset_timer - 20'd1);
    period_restart = (reset_timer == 20'd0) || (period_cnt >= reset_timer);
  end

  // Error-count clear period counter; parked at 0 when the period is 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      period_cnt <= '0;
    end else if (period_restart || period_hit) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 20'd1;
    end
  end

  // Saturating per-channel error counters; the periodic clear beats a pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) err_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (period_hit) begin
          err_cnt[i] <= '0;
        end else if (error_pulse[i] && (err_cnt[i] != CNT_MAX)) begin
          err_cnt[i] <= err_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Health from registered counts, then the best slot and the slot holding
  // the current channel (4 = not listed, i.e. lower than any listed slot).
  always_comb begin
    healthy    = '0;
    best_valid = 1'b0;
    best_ch    = '0;
    best_slot  = '0;
    cur_slot   = 3'd4;
    slot_ch    = '0;
    for (int i = 0; i < 4; i++) begin
      healthy[i] = signal_present[i] && ({24'd0, err_cnt[i]} < ERR_THRESH);
    end
    // Walk from the lowest priority upward so the highest slot wins last.
    for (int k = 3; k >= 0; k--) begin
      slot_ch = channel_priority[2*k +: 2];
      if (healthy[slot_ch]) begin
        best_valid = 1'b1;
        best_ch    = slot_ch;
        best_slot  = 3'(k);
      end
      if (slot_ch == active_channel) begin
        cur_slot = 3'(k);
      end
    end
    want_switch = best_valid && (best_ch != active_channel) &&
                  (!healthy[active_channel] || (best_slot < cur_slot));
  end

  // Next-state, next-channel and holdoff logic; manual override wins from
  // every state and also cancels any pending holdoff.
  always_comb begin
    state_nxt = state;
    ch_nxt    = active_channel;
    hold_nxt  = holdoff_cnt;
    if (manual_enable) begin
      state_nxt = S_MANUAL;
      ch_nxt    = manual_channel;
      hold_nxt  = '0;
    end else begin
      case (state)
        S_INIT: begin
          state_nxt = fallback_enable ? S_ACTIVE : S_FIXED;
        end
        S_MANUAL: begin
          state_nxt = fallback_enable ? S_ACTIVE : S_FIXED;
        end
        S_FIXED: begin
          if (fallback_enable) begin
            state_nxt = S_ACTIVE;
          end else begin
            ch_nxt = channel_priority[1:0];
          end
        end
        S_ACTIVE: begin
          if (!fallback_enable) begin
            state_nxt = S_FIXED;
          end else if (want_switch) begin
            ch_nxt    = best_ch;
            hold_nxt  = HOLD_LOAD;
            state_nxt = S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (!fallback_enable) begin
            state_nxt = S_FIXED;
            hold_nxt  = '0;
          end else if (holdoff_cnt <= 16'd1) begin
            state_nxt = S_ACTIVE;
            hold_nxt  = '0;
          end else begin
            hold_nxt = holdoff_cnt - 16'd1;
          end
        end
        default: begin
          state_nxt = S_INIT;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // State, selection and status registers; the pulse marks any real change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_INIT;
      active_channel <= '0;
      holdoff_cnt    <= '0;
      switch_pulse   <= 1'b0;
      no_signal      <= 1'b0;
    end else begin
      state          <= state_nxt;
      active_channel <= ch_nxt;
      holdoff_cnt    <= hold_nxt;
      switch_pulse   <= (ch_nxt != active_channel);
      no_signal      <= !best_valid;
    end
  end

endmodule
